fstore2_tty_writer: RTL and testbench

//  Glass-TTY front end for the fstore2 text display. Consumes an ASCII byte stream and writes

---
 rtl/fstore2_tty_writer.sv | 206 ++++++++++++++++++++
 tb/tb_fstore2_tty_writer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fstore2_tty_writer.sv
// Glass-TTY writer for the fstore2 text framebuffer: decodes an ASCII stream into RAM port-B writes.
// Optional macro FSTORE_TTY_LF_CR_EN: LF also returns the cursor to column 0.
module fstore2_tty_writer #(
  parameter int          COLS = 128,
  parameter int          ROWS = 32,
  parameter logic [7:0]  FILL = 8'h20
) (
  input  logic        clk_data,
  input  logic        irst_n,
  input  logic [7:0]  char_data,
  input  logic        char_valid,
  output logic        char_ready,
  output logic        enb,
  output logic [7:0]  web,
  output logic [10:0] addrb,
  output logic [63:0] dinb,
  output logic [5:0]  cur_row,
  output logic [6:0]  cur_col,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WRITE, CLR_ROW, CLR_ALL} state_t;

  localparam logic [6:0] COL_LAST  = 7'(COLS - 1);
  localparam logic [5:0] ROW_LAST  = 6'(ROWS - 1);
  localparam logic [3:0] WORD_LAST = 4'(COLS / 8 - 1);
  localparam logic [7:0] COLS_W    = 8'(COLS);

  state_t      state_q, state_d;
  logic [5:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [5:0]  crow_q, crow_d;
  logic [3:0]  cword_q, cword_d;
  logic        enb_q, enb_d;
  logic [7:0]  web_q, web_d;
  logic [10:0] addr_q, addr_d;
  logic [63:0] din_q, din_d;
  logic        in_rst_q;

  logic        nl;
  logic        clr_done;
  logic [7:0]  tab;

  function automatic logic [5:0] next_row(input logic [5:0] r);
    return (r == ROW_LAST) ? 6'd0 : r + 6'd1;
  endfunction

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    crow_d   = crow_q;
    cword_d  = cword_q;
    enb_d    = 1'b0;
    web_d    = '0;
    addr_d   = addr_q;
    din_d    = din_q;
    nl       = 1'b0;
    clr_done = 1'b0;
    tab      = ({1'b0, col_q} | 8'd7) + 8'd1;

    case (state_q)
      IDLE: begin
        if (char_valid) begin
          if (char_data >= 8'h20 && char_data <= 8'h7E) begin
            enb_d   = 1'b1;
            addr_d  = {1'b0, row_q, col_q[6:3]};
            web_d   = 8'h01 << col_q[2:0];
            din_d   = {8{char_data}};
            state_d = WRITE;
          end else begin
            case (char_data)
              8'h0D: col_d = '0;
              8'h0A: begin
                nl = 1'b1;
`ifdef FSTORE_TTY_LF_CR_EN
                col_d = '0;
`endif
              end
              8'h08: if (col_q != '0) col_d = col_q - 7'd1;
              8'h09: begin
                if (tab >= COLS_W) begin
                  col_d = '0;
                  nl    = 1'b1;
                end else begin
                  col_d = tab[6:0];
                end
              end
              8'h0C: begin
                row_d   = '0;
                col_d   = '0;
                crow_d  = '0;
                cword_d = '0;
                enb_d   = 1'b1;
                web_d   = '1;
                addr_d  = '0;
                din_d   = {8{FILL}};
                state_d = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end

      WRITE: begin
        state_d = IDLE;
        if (col_q == COL_LAST) begin
          col_d = '0;
          nl    = 1'b1;
        end else begin
          col_d = col_q + 7'd1;
        end
      end

      // enb_q low inside a clear state only right after reset: issue the
      // current word instead of advancing past it.
      CLR_ROW: begin
        if (enb_q) begin
          if (cword_q == WORD_LAST) clr_done = 1'b1;
          else                      cword_d  = cword_q + 4'd1;
        end
        if (clr_done) begin
          state_d = IDLE;
        end else begin
          enb_d  = 1'b1;
          web_d  = '1;
          addr_d = {1'b0, crow_d, cword_d};
          din_d  = {8{FILL}};
        end
      end

      CLR_ALL: begin
        if (enb_q) begin
          if (cword_q == WORD_LAST) begin
            if (crow_q == ROW_LAST) begin
              clr_done = 1'b1;
            end else begin
              crow_d  = crow_q + 6'd1;
              cword_d = '0;
            end
          end else begin
            cword_d = cword_q + 4'd1;
          end
        end
        if (clr_done) begin
          state_d = IDLE;
        end else begin
          enb_d  = 1'b1;
          web_d  = '1;
          addr_d = {1'b0, crow_d, cword_d};
          din_d  = {8{FILL}};
        end
      end

      default: state_d = IDLE;
    endcase

    if (nl) begin
      row_d   = next_row(row_q);
      crow_d  = row_d;
      cword_d = '0;
      enb_d   = 1'b1;
      web_d   = '1;
      addr_d  = {1'b0, row_d, 4'd0};
      din_d   = {8{FILL}};
      state_d = CLR_ROW;
    end
  end

  always_ff @(posedge clk_data) begin
    if (!irst_n) begin
      state_q  <= CLR_ALL;
      row_q    <= '0;
      col_q    <= '0;
      crow_q   <= '0;
      cword_q  <= '0;
      enb_q    <= 1'b0;
      web_q    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      in_rst_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      crow_q   <= crow_d;
      cword_q  <= cword_d;
      enb_q    <= enb_d;
      web_q    <= web_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      in_rst_q <= 1'b0;
    end
  end

  assign char_ready = (state_q == IDLE);
  assign busy       = (state_q == CLR_ROW || state_q == CLR_ALL) && !in_rst_q;
  assign enb        = enb_q;
  assign web        = web_q;
  assign addrb      = addr_q;
  assign dinb       = din_q;
  assign cur_row    = row_q;
  assign cur_col    = col_q;

endmodule

// File: tb/tb_fstore2_tty_writer.sv
// Self-checking bench for fstore2_tty_writer: queue-based write/cursor model plus literal pins.
module tb_fstore2_tty_writer;
  localparam int COLS = 128;
  localparam int ROWS = 32;
  localparam int WPR  = COLS / 8;
`ifdef FSTORE_TTY_LF_CR_EN
  localparam bit LF_CR = 1'b1;
`else
  localparam bit LF_CR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        irst_n;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic        enb;
  logic [7:0]  web;
  logic [10:0] addrb;
  logic [63:0] dinb;
  logic [5:0]  cur_row;
  logic [6:0]  cur_col;
  logic        busy;

  always #5 clk = ~clk;

  fstore2_tty_writer #(.COLS(COLS), .ROWS(ROWS), .FILL(8'h20)) dut (
    .clk_data(clk), .irst_n(irst_n), .char_data(char_data), .char_valid(char_valid),
    .char_ready(char_ready), .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
  );

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  web;
    logic [63:0] din;
    logic        clr;
  } wr_t;

  wr_t         expq[$];
  int          m_row = 0, m_col = 0;
  int          vectors = 0, miscompares = 0;
  bit          rst_active = 1'b1;
  int          stall = 0;
  int          nwrites = 0;
  logic [10:0] last_addr = '0, last_char_addr = '0;
  logic [7:0]  last_char_web = '0;
  logic [63:0] last_char_din = '0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_clear_row(input int r);
    wr_t e;
    for (int w = 0; w < WPR; w++) begin
      e.addr = 11'(r * 16 + w);
      e.web  = 8'hFF;
      e.din  = {8{8'h20}};
      e.clr  = 1'b1;
      expq.push_back(e);
    end
  endfunction

  function automatic void push_clear_all();
    for (int r = 0; r < ROWS; r++) push_clear_row(r);
  endfunction

  function automatic void newline();
    m_row = (m_row + 1) % ROWS;
    push_clear_row(m_row);
  endfunction

  function automatic void model_accept(input logic [7:0] c);
    wr_t e;
    int  t;
    if (c >= 8'h20 && c <= 8'h7E) begin
      e.addr = 11'(m_row * 16 + m_col / 8);
      e.web  = 8'(1 << (m_col % 8));
      e.din  = {8{c}};
      e.clr  = 1'b0;
      expq.push_back(e);
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        newline();
      end
    end else begin
      case (c)
        8'h0D: m_col = 0;
        8'h0A: begin
          if (LF_CR) m_col = 0;
          newline();
        end
        8'h08: if (m_col > 0) m_col--;
        8'h09: begin
          t = (m_col | 7) + 1;
          if (t >= COLS) begin
            m_col = 0;
            newline();
          end else begin
            m_col = t;
          end
        end
        8'h0C: begin
          m_row = 0;
          m_col = 0;
          push_clear_all();
        end
        default: ;
      endcase
    end
  endfunction

  // Output checker: every visible write must be the next expected one.
  always @(negedge clk) begin
    wr_t e;
    if (!rst_active) begin
      if (enb) begin
        stall = 0;
        if (expq.size() == 0) begin
          check("unexpected_write", {85'd0, addrb}, 96'h7FF_FFFF);
        end else begin
          e = expq.pop_front();
          check("write", {13'd0, addrb, web, dinb}, {13'd0, e.addr, e.web, e.din});
          check("busy_during_write", 96'(busy), 96'(e.clr));
        end
        nwrites++;
        last_addr = addrb;
        if (web != 8'hFF) begin
          last_char_addr = addrb;
          last_char_web  = web;
          last_char_din  = dinb;
        end
      end else begin
        if (expq.size() != 0) begin
          stall++;
          if (stall > 20) begin
            check("write_timeout", 96'(expq.size()), 96'd0);
            expq.delete();
            stall = 0;
          end
        end
        if (char_ready) begin
          check("idle_queue_empty", 96'(expq.size()), 96'd0);
          check("cursor", {83'd0, cur_row, cur_col}, {83'd0, 6'(m_row), 7'(m_col)});
          check("busy_idle", 96'(busy), 96'd0);
        end
      end
    end
  end

  task automatic do_reset(input int hold);
    @(posedge clk); #1;
    rst_active = 1'b1;
    irst_n     = 1'b0;
    char_valid = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    check("rst_ram_outputs", {12'd0, enb, web, addrb, dinb}, 96'd0);
    check("rst_ctl_outputs", {81'd0, cur_row, cur_col, char_ready, busy}, 96'd0);
    expq.delete();
    m_row = 0;
    m_col = 0;
    stall = 0;
    irst_n = 1'b1;
    push_clear_all();
    rst_active = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    bit done = 1'b0;
    @(posedge clk); #1;
    char_data  = c;
    char_valid = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (char_ready) begin
        @(posedge clk);
        model_accept(c);
        done = 1'b1;
      end
    end
    #1;
    char_valid = 1'b0;
    char_data  = 8'($urandom);
    if (!done) check("accept_timeout", 96'd0, 96'd1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (char_ready && expq.size() == 0) done = 1'b1;
    end
    if (!done) check("idle_timeout", 96'd0, 96'd1);
  endtask

  task automatic check_cursor(input string name, input int r, input int c);
    check(name, {83'd0, cur_row, cur_col}, {83'd0, 6'(r), 7'(c)});
  endtask

  initial begin
    int snap;
    int sel;
    logic [7:0] ch;
    irst_n     = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;

    do_reset(3);
    wait_idle();
    check("reset_clear_count", 96'(nwrites), 96'd512);
    check("reset_last_clear", 96'(last_addr), 96'd511);

    send(8'h41);
    wait_idle();
    check("A_write", {13'd0, last_char_addr, last_char_web, last_char_din},
          {13'd0, 11'd0, 8'h01, 64'h4141414141414141});
    check_cursor("A_cursor", 0, 1);

    send(8'h0C);
    wait_idle();
    for (int i = 0; i < 128; i++) send(8'(8'h21 + i % 94));
    wait_idle();
    check("wrap_last_char", {77'd0, last_char_addr, last_char_web}, {77'd0, 11'd15, 8'h80});
    check_cursor("wrap_cursor", 1, 0);
    check("wrap_last_clear", 96'(last_addr), 96'd31);

    repeat (3) send(8'h78);
    for (int i = 0; i < 30; i++) send(8'h0A);
    wait_idle();
    check_cursor("row31_cursor", 31, LF_CR ? 0 : 3);
    send(8'h0A);
    wait_idle();
    check_cursor("rowwrap_cursor", 0, LF_CR ? 0 : 3);
    check("rowwrap_last_clear", 96'(last_addr), 96'd15);

    send(8'h0D);
    repeat (5) send(8'h63);
    send(8'h08);
    wait_idle();
    check("bs_col", 96'(cur_col), 96'd4);
    send(8'h0D);
    repeat (5) send(8'h63);
    send(8'h09);
    wait_idle();
    check("tab_col", 96'(cur_col), 96'd8);
    send(8'h0D);
    wait_idle();
    check("cr_col", 96'(cur_col), 96'd0);
    send(8'h08);
    wait_idle();
    check("bs0_col", 96'(cur_col), 96'd0);
    snap = nwrites;
    send(8'h7F);
    wait_idle();
    check("del_no_write", 96'(nwrites - snap), 96'd0);

    repeat (3) send(8'h0A);
    send(8'h45);
    snap = nwrites;
    send(8'h0C);
    wait_idle();
    check_cursor("ff_cursor", 0, 0);
    check("ff_clear_count", 96'(nwrites - snap), 96'd513);

    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 70)      ch = 8'($urandom_range(32, 126));
      else if (sel < 76) ch = 8'h0D;
      else if (sel < 84) ch = 8'h0A;
      else if (sel < 90) ch = 8'h08;
      else if (sel < 96) ch = 8'h09;
      else if (sel < 99) ch = (i % 2 == 0) ? 8'h7F : 8'($urandom_range(128, 255));
      else               ch = 8'h0C;
      send(ch);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle();

    send(8'h0C);
    repeat (100) @(posedge clk);
    do_reset(1);
    wait_idle();
    check_cursor("postrst_cursor", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
